// File: rtl/dpd_lut_loader_if.sv
// Coefficient stream and actuator LUT config port of the DPD LUT loader.
// The master modport is the loader; the slave modport is the stream source / actuator side.
interface dpd_lut_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_LUTS   = 64
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic [ADDR_WIDTH-1:0] config_addr;
    logic [DATA_WIDTH-1:0] config_din;
    logic [NUM_LUTS-1:0]   config_lutId;
    logic                  config_web;

    modport master (
        input  s_valid,
        input  s_data,
        output s_ready,
        output config_addr,
        output config_din,
        output config_lutId,
        output config_web
    );

    modport slave (
        output s_valid,
        output s_data,
        input  s_ready,
        input  config_addr,
        input  config_din,
        input  config_lutId,
        input  config_web
    );
endinterface

// File: rtl/dpd_lut_loader.sv
// Streams coefficients into the masked DPD LUTs while holding the actuator in bypass,
// with guard intervals before and after the writes so the actuator pipeline is flushed.
module dpd_lut_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int NUM_LUTS   = 64,
    parameter int GUARD      = 22
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [NUM_LUTS-1:0] lut_mask,
    dpd_lut_loader_if.master    bus,
    output logic                bypass,
    output logic                busy,
    output logic                done,
    output logic                aborted
);
    localparam int SEL_W = (NUM_LUTS > 1) ? $clog2(NUM_LUTS) : 1;
    localparam int GRD_W = (GUARD > 1) ? $clog2(GUARD) : 1;
    localparam logic [GRD_W-1:0]      GRD_LAST  = GRD_W'(GUARD - 1);
    localparam logic [ADDR_WIDTH-1:0] WORD_LAST = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_SCAN,
        S_WRITE,
        S_POST,
        S_FIN
    } state_e;

    state_e                state_q,      state_d;
    logic [NUM_LUTS-1:0]   mask_q,       mask_d;
    logic [SEL_W-1:0]      idx_q,        idx_d;
    logic [GRD_W-1:0]      grd_q,        grd_d;
    logic [ADDR_WIDTH-1:0] word_q,       word_d;
    logic                  abort_seen_q, abort_seen_d;
    logic                  web_q,        web_d;
    logic [ADDR_WIDTH-1:0] addr_q,       addr_d;
    logic [DATA_WIDTH-1:0] din_q,        din_d;
    logic [NUM_LUTS-1:0]   lut_id_q,     lut_id_d;

    logic [NUM_LUTS-1:0] lut_onehot;
    logic                abortable;
    logic                xfer;

    assign lut_onehot = NUM_LUTS'(1) << idx_q;
    assign abortable  = (state_q == S_PRE) || (state_q == S_SCAN) || (state_q == S_WRITE);
    // A word coincident with abort is refused, so it never reaches the LUT.
    assign xfer       = (state_q == S_WRITE) && bus.s_valid && !abort;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mask_q       <= '0;
            idx_q        <= '0;
            grd_q        <= '0;
            word_q       <= '0;
            abort_seen_q <= 1'b0;
            web_q        <= 1'b0;
            addr_q       <= '0;
            din_q        <= '0;
            lut_id_q     <= '0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            idx_q        <= idx_d;
            grd_q        <= grd_d;
            word_q       <= word_d;
            abort_seen_q <= abort_seen_d;
            web_q        <= web_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            lut_id_q     <= lut_id_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        idx_d        = idx_q;
        grd_d        = grd_q;
        word_d       = word_q;
        abort_seen_d = abort_seen_q;

        if (abortable && abort) begin
            state_d      = S_POST;
            grd_d        = '0;
            abort_seen_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        abort_seen_d = 1'b0;
                        idx_d        = '0;
                        grd_d        = '0;
                        word_d       = '0;
                        if (lut_mask != '0) begin
                            state_d = S_PRE;
                            mask_d  = lut_mask;
                        end else begin
                            state_d = S_FIN;
                        end
                    end
                end
                S_PRE: begin
                    if (grd_q == GRD_LAST) begin
                        state_d = S_SCAN;
                        idx_d   = '0;
                        grd_d   = '0;
                    end else begin
                        grd_d = grd_q + 1'b1;
                    end
                end
                S_SCAN: begin
                    // Finished LUTs are cleared from the mask, so an empty mask means nothing is left.
                    if (mask_q == '0) begin
                        state_d = S_POST;
                        grd_d   = '0;
                    end else if (mask_q[idx_q]) begin
                        state_d = S_WRITE;
                        word_d  = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (bus.s_valid) begin
                        if (word_q == WORD_LAST) begin
                            state_d = S_SCAN;
                            idx_d   = idx_q + 1'b1;
                            mask_d  = mask_q & ~lut_onehot;
                        end else begin
                            word_d = word_q + 1'b1;
                        end
                    end
                end
                S_POST: begin
                    if (grd_q == GRD_LAST) begin
                        state_d = S_FIN;
                        grd_d   = '0;
                    end else begin
                        grd_d = grd_q + 1'b1;
                    end
                end
                S_FIN:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        web_d    = xfer;
        lut_id_d = xfer ? lut_onehot : '0;
        addr_d   = xfer ? word_q : addr_q;
        din_d    = xfer ? bus.s_data : din_q;
    end

    always_comb begin
        bypass      = (state_q == S_PRE) || (state_q == S_SCAN) ||
                      (state_q == S_WRITE) || (state_q == S_POST);
        busy        = bypass;
        bus.s_ready = (state_q == S_WRITE) && !abort;
        done        = (state_q == S_FIN);
        aborted     = (state_q == S_FIN) && abort_seen_q;
    end

    assign bus.config_web   = web_q;
    assign bus.config_addr  = addr_q;
    assign bus.config_din   = din_q;
    assign bus.config_lutId = lut_id_q;
endmodule

// File: tb/tb_dpd_lut_loader.sv
// Randomized bench for dpd_lut_loader against a per-cycle phase timeline and expected-write list
// built from the load rules (guards, scan walk, 2^ADDR_WIDTH words per LUT, abort, reset).
module tb_dpd_lut_loader;
    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int NL    = 64;
    localparam int G     = 22;
    localparam int WORDS = 1 << AW;

    typedef enum int {K_IDLE, K_PRE, K_SCAN, K_WRITE, K_POST, K_FIN} kind_e;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NL-1:0] lut_mask = '0;
    logic          bypass, busy, done, aborted;

    dpd_lut_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LUTS(NL)) bus ();

    dpd_lut_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LUTS(NL), .GUARD(G)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .lut_mask (lut_mask),
        .bus      (bus),
        .bypass   (bypass),
        .busy     (busy),
        .done     (done),
        .aborted  (aborted)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] all_out();
        return {bypass, busy, done, aborted, bus.s_ready, bus.config_web,
                bus.config_lutId, bus.config_addr, bus.config_din};
    endfunction

    // Reference model: one timeline entry per cycle; a K_WRITE entry lasts until WORDS transfers.
    kind_e         sched[$];
    int            luts[$];
    int            words, xfers, wr_cycles, scan_exp;
    bit            exp_abt;
    bit            pend_v;
    int            pend_lut, pend_addr;
    logic [DW-1:0] pend_din;
    int            web_cnt, byp_cnt;
    kind_e         cur_k;
    logic [4:0]    exp_ctl;
    logic [NL-1:0] exp_lut;

    function automatic void build(input logic [NL-1:0] m);
        int idx;
        exp_abt   = 1'b0;
        words     = 0;
        xfers     = 0;
        wr_cycles = 0;
        scan_exp  = 0;
        if (m == '0) begin
            sched.push_back(K_FIN);
            return;
        end
        repeat (G) sched.push_back(K_PRE);
        idx = 0;
        for (int b = 0; b < NL; b++) begin
            if (m[b]) begin
                repeat (b - idx + 1) sched.push_back(K_SCAN);
                scan_exp += b - idx + 1;
                sched.push_back(K_WRITE);
                luts.push_back(b);
                idx = b + 1;
            end
        end
        sched.push_back(K_SCAN);
        scan_exp++;
        repeat (G) sched.push_back(K_POST);
        sched.push_back(K_FIN);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_out", all_out(), '0);
            sched.delete();
            luts.delete();
            pend_v = 1'b0;
            words  = 0;
        end else begin
            cur_k = (sched.size() != 0) ? sched[0] : K_IDLE;
            exp_ctl[4] = cur_k inside {K_PRE, K_SCAN, K_WRITE, K_POST};
            exp_ctl[3] = exp_ctl[4];
            exp_ctl[2] = (cur_k == K_WRITE) && !abort;
            exp_ctl[1] = (cur_k == K_FIN);
            exp_ctl[0] = (cur_k == K_FIN) && exp_abt;
            check("ctl(byp,busy,rdy,done,abt)", {bypass, busy, bus.s_ready, done, aborted}, exp_ctl);
            check("web", bus.config_web, pend_v);
            if (pend_v) begin
                exp_lut = '0;
                exp_lut[pend_lut] = 1'b1;
                check("lut_id", bus.config_lutId, exp_lut);
                check("addr", bus.config_addr, pend_addr);
                check("din", bus.config_din, pend_din);
            end else begin
                check("lut_id_idle", bus.config_lutId, '0);
            end
            if (bus.config_web) web_cnt++;
            if (bypass) byp_cnt++;

            pend_v = 1'b0;
            if (cur_k == K_IDLE) begin
                if (start && !abort) build(lut_mask);
            end else if (abort && (cur_k inside {K_PRE, K_SCAN, K_WRITE})) begin
                sched.delete();
                luts.delete();
                repeat (G) sched.push_back(K_POST);
                sched.push_back(K_FIN);
                exp_abt = 1'b1;
            end else if (cur_k == K_WRITE) begin
                wr_cycles++;
                if (bus.s_valid) begin
                    pend_v    = 1'b1;
                    pend_lut  = luts[0];
                    pend_addr = words;
                    pend_din  = bus.s_data;
                    xfers++;
                    words++;
                    if (words == WORDS) begin
                        words = 0;
                        void'(luts.pop_front());
                        void'(sched.pop_front());
                    end
                end
            end else begin
                void'(sched.pop_front());
            end
        end
    end

    task automatic drive_stream(input int vmode, input int cyc);
        case (vmode)
            0:       bus.s_valid = 1'b1;
            1:       bus.s_valid = (cyc % 2 == 0);
            default: bus.s_valid = ($urandom_range(0, 99) < 70);
        endcase
        bus.s_data = $urandom;
    endtask

    // abort_at: -1 none, -2 abort during PRE, >=0 abort at that transfer; rst_at: transfer to reset at.
    task automatic run_load(input string name, input logic [NL-1:0] mask, input int vmode,
                            input int abort_at, input int rst_at);
        int  cyc;
        int  exp_writes;
        bit  was_reset;
        cyc       = 0;
        was_reset = 1'b0;
        web_cnt   = 0;
        byp_cnt   = 0;
        @(posedge clk); #1;
        start    = 1'b1;
        lut_mask = mask;
        drive_stream(vmode, 0);
        @(posedge clk); #1;
        start = 1'b0;
        while (sched.size() != 0 && cyc < 20000) begin
            drive_stream(vmode, cyc);
            lut_mask = {$urandom, $urandom};
            start    = ($urandom_range(0, 31) == 0);
            abort    = 1'b0;
            if (abort_at >= 0 && xfers == abort_at && sched[0] == K_WRITE) begin
                abort       = 1'b1;
                bus.s_valid = 1'b1;
            end else if (abort_at == -2 && cyc == 5) begin
                abort = 1'b1;
            end else if (sched[0] == K_POST) begin
                abort = ($urandom_range(0, 3) == 0);
            end
            if (rst_at >= 0 && xfers == rst_at && sched[0] == K_WRITE) begin
                #2 rst_n = 1'b0;
                #1 check({name, ":rst_async"}, all_out(), '0);
                @(negedge clk);
                @(posedge clk); #1;
                rst_n     = 1'b1;
                was_reset = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start       = 1'b0;
        abort       = 1'b0;
        bus.s_valid = 1'b0;
        if (cyc >= 20000) check({name, ":timeout"}, 1'b1, 1'b0);
        if (!was_reset) begin
            if (abort_at >= 0)       exp_writes = abort_at;
            else if (abort_at == -2) exp_writes = 0;
            else                     exp_writes = $countones(mask) * WORDS;
            check({name, ":n_writes"}, web_cnt, exp_writes);
            if (abort_at == -1) begin
                if (mask == '0) check({name, ":byp_len"}, byp_cnt, 0);
                else check({name, ":byp_len"}, byp_cnt, 2 * G + scan_exp + wr_cycles);
            end
        end
    endtask

    initial begin
        logic [NL-1:0] m;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("rst_hold", all_out(), '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_load("bit0", 64'h1, 0, -1, -1);
        run_load("b5_b63", (64'h1 << 5) | (64'h1 << 63), 0, -1, -1);
        run_load("alt_valid", 64'h4, 1, -1, -1);
        m = '0;
        repeat (3) m[$urandom_range(0, NL - 1)] = 1'b1;
        run_load("rand_mask", m, 2, -1, -1);
        run_load("abort_w100", 64'h1, 0, 100, -1);
        run_load("abort_pre", {$urandom, $urandom} | 64'h1, 2, -2, -1);
        run_load("mask_zero", 64'h0, 0, -1, -1);

        @(posedge clk); #1;
        start    = 1'b1;
        abort    = 1'b1;
        lut_mask = 64'h1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("abort_start:busy", busy, 1'b0);
        check("abort_start:done", done, 1'b0);

        run_load("rst_mid", 64'h3, 2, -1, 300);
        run_load("after_rst", 64'h80, 2, -1, -1);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
